// File: rtl/data_to_l2_serializer_if.sv
// Bundle of the cache-side line handshake and the L2-side beat bus.
// The master modport is the serializer: it takes lines in and drives beats out.
// The slave modport is the environment around it (cache side plus L2).
interface data_to_l2_serializer_if #(
    parameter int L2_BUS_WIDTH = 64,
    parameter int BUFFER_WIDTH = 128
);
    logic                    DATA_TO_L2_BUFFER_VALID;
    logic                    DATA_TO_L2_BUFFER_READY;
    logic [BUFFER_WIDTH-1:0] DATA_TO_L2_BUFFER;
    logic                    DATA_TO_L2_VALID;
    logic                    DATA_TO_L2_READY;
    logic [L2_BUS_WIDTH-1:0] DATA_TO_L2;
    logic                    DATA_TO_L2_LAST;

    modport master (
        input  DATA_TO_L2_BUFFER_VALID,
        input  DATA_TO_L2_BUFFER,
        input  DATA_TO_L2_READY,
        output DATA_TO_L2_BUFFER_READY,
        output DATA_TO_L2_VALID,
        output DATA_TO_L2,
        output DATA_TO_L2_LAST
    );

    modport slave (
        output DATA_TO_L2_BUFFER_VALID,
        output DATA_TO_L2_BUFFER,
        output DATA_TO_L2_READY,
        input  DATA_TO_L2_BUFFER_READY,
        input  DATA_TO_L2_VALID,
        input  DATA_TO_L2,
        input  DATA_TO_L2_LAST
    );
endinterface

// File: rtl/data_to_l2_serializer.sv
// Transmit side of the L1->L2 data path. Holds one BUFFER_WIDTH line and
// sends it as BUFFER_WIDTH/L2_BUS_WIDTH beats, least-significant slice first.
// The line input is re-opened combinationally on the final beat transfer so
// back-to-back lines stream without a bubble.
module data_to_l2_serializer #(
    parameter int L2_BUS_WIDTH = 64,
    parameter int BUFFER_WIDTH = 128
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          ENB,
    data_to_l2_serializer_if.master       bus
);

    localparam int BEATS = BUFFER_WIDTH / L2_BUS_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                                state_r;
    state_t                                state_s;
    logic [CW-1:0]                         beat_r;
    logic [CW-1:0]                         beat_s;
    logic [BEATS-1:0][L2_BUS_WIDTH-1:0]    line_r;
    logic [BEATS-1:0][L2_BUS_WIDTH-1:0]    line_s;

    logic at_last_s;
    logic valid_s;
    logic ready_s;
    logic acc_s;
    logic xfer_s;

    assign at_last_s = (beat_r == LAST_BEAT);
    assign acc_s     = bus.DATA_TO_L2_BUFFER_VALID & ready_s;
    assign xfer_s    = valid_s & bus.DATA_TO_L2_READY;

    // State, beat counter and holding line; ENB low freezes everything.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_r <= IDLE;
            beat_r  <= '0;
            line_r  <= '0;
        end else if (ENB) begin
            state_r <= state_s;
            beat_r  <= beat_s;
            line_r  <= line_s;
        end
    end

    // Next state: load on accept, advance on beat transfer, reload or idle after the last beat.
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        line_s  = line_r;
        case (state_r)
            IDLE: begin
                if (acc_s) begin
                    line_s  = bus.DATA_TO_L2_BUFFER;
                    beat_s  = '0;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (xfer_s) begin
                    if (!at_last_s) begin
                        beat_s = beat_r + CW'(1);
                    end else if (acc_s) begin
                        line_s  = bus.DATA_TO_L2_BUFFER;
                        beat_s  = '0;
                        state_s = SEND;
                    end else begin
                        beat_s  = '0;
                        state_s = IDLE;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                state_s = IDLE;
                beat_s  = '0;
            end
        endcase
    end

    // Handshake outputs and beat data; reset or stall forces every output to zero.
    always_comb begin
        valid_s = RSTN & ENB & (state_r == SEND);
        ready_s = RSTN & ENB & ((state_r == IDLE) |
                               ((state_r == SEND) & at_last_s & bus.DATA_TO_L2_READY));
        bus.DATA_TO_L2_VALID        = valid_s;
        bus.DATA_TO_L2_BUFFER_READY = ready_s;
        if (valid_s) begin
            bus.DATA_TO_L2      = line_r[beat_r];
            bus.DATA_TO_L2_LAST = at_last_s;
        end else begin
            bus.DATA_TO_L2      = '0;
            bus.DATA_TO_L2_LAST = 1'b0;
        end
    end

endmodule

// File: tb/tb_data_to_l2_serializer.sv
// Bench for data_to_l2_serializer: a 2-beat (128/64) instance for directed
// steps and a 4-beat (256/64) instance for randomized traffic. A queue of
// pending beats per instance predicts every output each cycle.
module tb_data_to_l2_serializer;

    logic CLK = 1'b0;
    logic RSTN;
    logic ENB;

    always #5 CLK = ~CLK;

    data_to_l2_serializer_if #(.L2_BUS_WIDTH(64), .BUFFER_WIDTH(128)) ifa ();
    data_to_l2_serializer_if #(.L2_BUS_WIDTH(64), .BUFFER_WIDTH(256)) ifb ();

    data_to_l2_serializer #(.L2_BUS_WIDTH(64), .BUFFER_WIDTH(128)) dut_a (
        .CLK (CLK),
        .RSTN(RSTN),
        .ENB (ENB),
        .bus (ifa.master)
    );

    data_to_l2_serializer #(.L2_BUS_WIDTH(64), .BUFFER_WIDTH(256)) dut_b (
        .CLK (CLK),
        .RSTN(RSTN),
        .ENB (ENB),
        .bus (ifb.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // sampled outputs (taken on the falling edge)
    logic        a_v, a_r, a_l, b_v, b_r, b_l;
    logic [63:0] a_d, b_d;

    // reference model: beats still owed to L2, plus the lines of B for rebuild
    logic [63:0]  qa[$];
    logic [63:0]  qb[$];
    logic [255:0] lines_b[$];
    logic [255:0] rebuild;
    int           rb_cnt = 0;
    int           n_lines_b = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_check(input int id);
        logic        v, r, l, l2r, bv, ev, er, el, xfer, acc;
        logic [63:0] d, ed, front;
        logic [255:0] ln, got;
        int beats, sz;
        string nm;
        if (id == 0) begin
            v = a_v; r = a_r; l = a_l; d = a_d; nm = "A";
            l2r = ifa.DATA_TO_L2_READY; bv = ifa.DATA_TO_L2_BUFFER_VALID;
            ln = {128'd0, ifa.DATA_TO_L2_BUFFER}; beats = 2; sz = qa.size();
            front = (sz > 0) ? qa[0] : 64'd0;
        end else begin
            v = b_v; r = b_r; l = b_l; d = b_d; nm = "B";
            l2r = ifb.DATA_TO_L2_READY; bv = ifb.DATA_TO_L2_BUFFER_VALID;
            ln = ifb.DATA_TO_L2_BUFFER; beats = 4; sz = qb.size();
            front = (sz > 0) ? qb[0] : 64'd0;
        end
        ev = RSTN & ENB & (sz > 0);
        er = RSTN & ENB & ((sz == 0) | ((sz == 1) & l2r));
        el = ev & (sz == 1);
        ed = ev ? front : 64'd0;
        chk({nm, ".model.valid"}, 256'(v), 256'(ev));
        chk({nm, ".model.buf_ready"}, 256'(r), 256'(er));
        chk({nm, ".model.last"}, 256'(l), 256'(el));
        chk({nm, ".model.data"}, 256'(d), 256'(ed));
        xfer = ev & l2r;
        acc  = bv & er;
        if (!RSTN) begin
            if (id == 0) qa.delete();
            else begin
                qb.delete();
                lines_b.delete();
                rb_cnt = 0;
            end
        end else begin
            if (xfer) begin
                if (id == 0) void'(qa.pop_front());
                else begin
                    void'(qb.pop_front());
                    rebuild[rb_cnt*64 +: 64] = d;
                    rb_cnt++;
                    if (rb_cnt == 4) begin
                        got = (lines_b.size() > 0) ? lines_b.pop_front() : 256'd0;
                        chk("B.rebuild_line", rebuild, got);
                        rb_cnt = 0;
                        n_lines_b++;
                    end
                end
            end
            if (acc) begin
                for (int k = 0; k < beats; k++) begin
                    if (id == 0) qa.push_back(ln[k*64 +: 64]);
                    else qb.push_back(ln[k*64 +: 64]);
                end
                if (id == 1) lines_b.push_back(ln);
            end
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        a_v = ifa.DATA_TO_L2_VALID; a_r = ifa.DATA_TO_L2_BUFFER_READY;
        a_l = ifa.DATA_TO_L2_LAST;  a_d = ifa.DATA_TO_L2;
        b_v = ifb.DATA_TO_L2_VALID; b_r = ifb.DATA_TO_L2_BUFFER_READY;
        b_l = ifb.DATA_TO_L2_LAST;  b_d = ifb.DATA_TO_L2;
        model_check(0);
        model_check(1);
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] lns [3];
        logic [127:0] cur;
        logic [127:0] ln_d;
        logic [127:0] ln_e;

        // 1: reset with everything asserted
        RSTN = 1'b0; ENB = 1'b1;
        ifa.DATA_TO_L2_BUFFER_VALID = 1'b1; ifa.DATA_TO_L2_READY = 1'b1;
        ifa.DATA_TO_L2_BUFFER = rnd256()[127:0];
        ifb.DATA_TO_L2_BUFFER_VALID = 1'b1; ifb.DATA_TO_L2_READY = 1'b1;
        ifb.DATA_TO_L2_BUFFER = rnd256();
        cyc(); cyc();
        chk("rst.valid", 256'(a_v), 256'(1'b0));
        chk("rst.buf_ready", 256'(a_r), 256'(1'b0));
        chk("rst.last", 256'(a_l), 256'(1'b0));
        chk("rst.data", 256'(a_d), 256'd0);
        RSTN = 1'b1;
        ifa.DATA_TO_L2_BUFFER_VALID = 1'b0; ifb.DATA_TO_L2_BUFFER_VALID = 1'b0;
        cyc();
        chk("post_rst.buf_ready", 256'(a_r), 256'(1'b1));
        chk("post_rst.valid", 256'(a_v), 256'(1'b0));

        // 2: single line, two beats, low slice first
        ifa.DATA_TO_L2_BUFFER = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        ifa.DATA_TO_L2_BUFFER_VALID = 1'b1;
        cyc();
        chk("single.accept", 256'(a_r), 256'(1'b1));
        ifa.DATA_TO_L2_BUFFER_VALID = 1'b0;
        cyc();
        chk("single.b0.valid", 256'(a_v), 256'(1'b1));
        chk("single.b0.data", 256'(a_d), 256'(64'hAAAA_AAAA_AAAA_AAAA));
        chk("single.b0.last", 256'(a_l), 256'(1'b0));
        cyc();
        chk("single.b1.data", 256'(a_d), 256'(64'hBBBB_BBBB_BBBB_BBBB));
        chk("single.b1.last", 256'(a_l), 256'(1'b1));
        cyc();
        chk("single.done.valid", 256'(a_v), 256'(1'b0));

        // 3: backpressure on beat 0
        ifa.DATA_TO_L2_BUFFER = {64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
        ifa.DATA_TO_L2_BUFFER_VALID = 1'b1;
        cyc();
        ifa.DATA_TO_L2_BUFFER_VALID = 1'b0; ifa.DATA_TO_L2_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp.hold.valid", 256'(a_v), 256'(1'b1));
            chk("bp.hold.data", 256'(a_d), 256'(64'hC0C0_C0C0_C0C0_C0C0));
            chk("bp.hold.buf_ready", 256'(a_r), 256'(1'b0));
        end
        ifa.DATA_TO_L2_READY = 1'b1;
        cyc();
        chk("bp.b0.data", 256'(a_d), 256'(64'hC0C0_C0C0_C0C0_C0C0));
        cyc();
        chk("bp.b1.data", 256'(a_d), 256'(64'hC1C1_C1C1_C1C1_C1C1));
        chk("bp.b1.last", 256'(a_l), 256'(1'b1));
        cyc();
        chk("bp.done.valid", 256'(a_v), 256'(1'b0));

        // 4: three lines back to back, no bubble
        for (int i = 0; i < 3; i++) lns[i] = rnd256()[127:0];
        ifa.DATA_TO_L2_BUFFER = lns[0]; ifa.DATA_TO_L2_BUFFER_VALID = 1'b1;
        cyc();
        chk("b2b.accept0", 256'(a_r), 256'(1'b1));
        for (int c = 1; c <= 6; c++) begin
            ifa.DATA_TO_L2_BUFFER_VALID = (c < 5);
            if (c < 5) ifa.DATA_TO_L2_BUFFER = lns[(c+1)/2];
            cyc();
            cur = lns[(c-1)/2];
            chk("b2b.valid", 256'(a_v), 256'(1'b1));
            chk("b2b.data", 256'(a_d), 256'(cur[((c-1)%2)*64 +: 64]));
            chk("b2b.last", 256'(a_l), 256'((c % 2) == 0));
            chk("b2b.buf_ready", 256'(a_r), 256'((c % 2) == 0));
        end
        ifa.DATA_TO_L2_BUFFER_VALID = 1'b0;
        cyc();
        chk("b2b.done.valid", 256'(a_v), 256'(1'b0));

        // 5a: stall during beat 1, beat 1 resent afterwards
        ln_d = rnd256()[127:0];
        ifa.DATA_TO_L2_BUFFER = ln_d; ifa.DATA_TO_L2_BUFFER_VALID = 1'b1;
        cyc();
        ifa.DATA_TO_L2_BUFFER_VALID = 1'b0;
        cyc();
        chk("stall.b0.data", 256'(a_d), 256'(ln_d[63:0]));
        ENB = 1'b0;
        cyc();
        chk("stall.valid", 256'(a_v), 256'(1'b0));
        chk("stall.data", 256'(a_d), 256'd0);
        chk("stall.buf_ready", 256'(a_r), 256'(1'b0));
        cyc();
        ENB = 1'b1;
        cyc();
        chk("stall.b1.valid", 256'(a_v), 256'(1'b1));
        chk("stall.b1.data", 256'(a_d), 256'(ln_d[127:64]));
        chk("stall.b1.last", 256'(a_l), 256'(1'b1));
        cyc();

        // 5b: reset during beat 1 drops it
        ln_e = rnd256()[127:0];
        ifa.DATA_TO_L2_BUFFER = ln_e; ifa.DATA_TO_L2_BUFFER_VALID = 1'b1;
        cyc();
        ifa.DATA_TO_L2_BUFFER_VALID = 1'b0;
        cyc();
        chk("rstmid.b0.data", 256'(a_d), 256'(ln_e[63:0]));
        RSTN = 1'b0;
        cyc();
        chk("rstmid.valid", 256'(a_v), 256'(1'b0));
        RSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rstmid.after.valid", 256'(a_v), 256'(1'b0));
            chk("rstmid.after.buf_ready", 256'(a_r), 256'(1'b1));
        end

        // 6: randomized traffic on both instances, 4-beat lines rebuilt by the model
        for (int i = 0; i < 800; i++) begin
            ENB = ($urandom_range(0, 19) != 0);
            ifa.DATA_TO_L2_BUFFER_VALID = ($urandom_range(0, 3) != 0);
            ifa.DATA_TO_L2_READY        = ($urandom_range(0, 3) != 0);
            ifa.DATA_TO_L2_BUFFER       = rnd256()[127:0];
            ifb.DATA_TO_L2_BUFFER_VALID = ($urandom_range(0, 3) != 0);
            ifb.DATA_TO_L2_READY        = ($urandom_range(0, 3) != 0);
            ifb.DATA_TO_L2_BUFFER       = rnd256();
            cyc();
        end
        ENB = 1'b1;
        ifa.DATA_TO_L2_BUFFER_VALID = 1'b0; ifa.DATA_TO_L2_READY = 1'b1;
        ifb.DATA_TO_L2_BUFFER_VALID = 1'b0; ifb.DATA_TO_L2_READY = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("rand.lines_rebuilt_enough", 256'(n_lines_b > 50), 256'(1'b1));
        chk("rand.b.drained", 256'(b_v), 256'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
